// File: rtl/music_pkg.sv
// Shared definitions for the note sequencer: default geometry, beat rate and
// the controller state encoding (also driven onto the LED state output).
package music_pkg;

   localparam int ADDR_W_DEF         = 4;
   localparam int NOTE_W_DEF         = 5;
   localparam int DUR_W_DEF          = 2;
   localparam int TICKS_PER_BEAT_DEF = 12500000;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PLAY_FETCH = 2'd1,
      ST_PLAY_LOAD  = 2'd2,
      ST_PLAY_NOTE  = 2'd3
   } seq_state_e;

   // Width of a down-counter covering 0..ticks-1; never narrower than one bit.
   function automatic int tick_width(input int ticks);
      return (ticks > 1) ? $clog2(ticks) : 1;
   endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Note RAM port and tone generator port of the sequencer, bundled so the
// sequencer (master) and the RAM/tone side (slave) share one connection.
interface note_sequencer_if
   import music_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NOTE_W = NOTE_W_DEF,
   parameter int DUR_W  = DUR_W_DEF
);

   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [NOTE_W+DUR_W-1:0] mem_wdata;
   logic [NOTE_W+DUR_W-1:0] mem_rdata;
   logic                    tone_en;
   logic [NOTE_W-1:0]       tone_note;

   modport master (
      output mem_we, mem_addr, mem_wdata, tone_en, tone_note,
      input  mem_rdata
   );

   modport slave (
      input  mem_we, mem_addr, mem_wdata, tone_en, tone_note,
      output mem_rdata
   );

endinterface

// File: rtl/beat_timer.sv
// Note length timer: counts TICKS_PER_BEAT cycles per beat for dur+1 beats
// while enabled and flags the last cycle of the note with done.
module beat_timer
   import music_pkg::*;
#(
   parameter int DUR_W          = DUR_W_DEF,
   parameter int TICKS_PER_BEAT = TICKS_PER_BEAT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DUR_W-1:0] dur,
   input  logic             enable,
   output logic             done
);

   localparam int                TICK_W   = tick_width(TICKS_PER_BEAT);
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_BEAT - 1);

   logic [TICK_W-1:0] tick_q, tick_d;
   logic [DUR_W-1:0]  beat_q, beat_d;

   always_comb begin
      tick_d = tick_q;
      beat_d = beat_q;
      done   = 1'b0;
      if (load) begin
         tick_d = TICK_MAX;
         beat_d = dur;
      end else if (enable) begin
         if (tick_q != '0) begin
            tick_d = tick_q - 1'b1;
         end else if (beat_q != '0) begin
            beat_d = beat_q - 1'b1;
            tick_d = TICK_MAX;
         end else begin
            done = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_q <= '0;
         beat_q <= '0;
      end else begin
         tick_q <= tick_d;
         beat_q <= beat_d;
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Record/playback scheduler for the note RAM and tone generator.
// Optional macro NOTE_SEQUENCER_LIVE_OVERRIDE_EN lets live keys override playback.
module note_sequencer
   import music_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int NOTE_W         = NOTE_W_DEF,
   parameter int DUR_W          = DUR_W_DEF,
   parameter int TICKS_PER_BEAT = TICKS_PER_BEAT_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rec_n,
   input  logic               play_n,
   input  logic               stop_n,
   input  logic               loop_en,
   input  logic [NOTE_W-1:0]  note_in,
   input  logic [DUR_W-1:0]   dur_in,
   input  logic               live_valid,
   input  logic [NOTE_W-1:0]  live_note,
   note_sequencer_if.master   bus,
   output logic [1:0]         state,
   output logic [ADDR_W:0]    notes_recorded,
   output logic               rec_full
);

   localparam int               CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(2 ** ADDR_W);

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] play_ptr_q, play_ptr_d;
   logic [NOTE_W-1:0] cur_note_q, cur_note_d;
   logic              rec_hist_q, play_hist_q, stop_hist_q;

   logic rec_press, play_press, stop_press;
   logic tmr_load, tmr_en, tmr_done;

   // A press is the cycle where the button is low but was high last cycle.
   assign rec_press  = rec_hist_q  & ~rec_n;
   assign play_press = play_hist_q & ~play_n;
   assign stop_press = stop_hist_q & ~stop_n;

   assign state          = state_q;
   assign notes_recorded = count_q;
   assign rec_full       = (count_q == CAPACITY);

   beat_timer #(
      .DUR_W          (DUR_W),
      .TICKS_PER_BEAT (TICKS_PER_BEAT)
   ) u_beat_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (tmr_load),
      .dur    (bus.mem_rdata[NOTE_W +: DUR_W]),
      .enable (tmr_en),
      .done   (tmr_done)
   );

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      play_ptr_d    = play_ptr_q;
      cur_note_d    = cur_note_q;
      tmr_load      = 1'b0;
      tmr_en        = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = {dur_in, note_in};
      bus.tone_en   = 1'b0;
      bus.tone_note = '0;

      unique case (state_q)
         ST_IDLE: begin
            bus.tone_en   = live_valid;
            bus.tone_note = live_note;
            // The highest-priority press consumes the cycle, even if ignored.
            if (stop_press) begin
               count_d = '0;
            end else if (play_press) begin
               if (count_q != '0) begin
                  play_ptr_d = '0;
                  state_d    = ST_PLAY_FETCH;
               end
            end else if (rec_press && !rec_full) begin
               bus.mem_we   = 1'b1;
               bus.mem_addr = count_q[ADDR_W-1:0];
               count_d      = count_q + 1'b1;
            end
         end
         ST_PLAY_FETCH: begin
            bus.mem_addr = play_ptr_q;
            state_d      = ST_PLAY_LOAD;
         end
         ST_PLAY_LOAD: begin
            bus.mem_addr = play_ptr_q;
            cur_note_d   = bus.mem_rdata[NOTE_W-1:0];
            tmr_load     = 1'b1;
            state_d      = ST_PLAY_NOTE;
         end
         ST_PLAY_NOTE: begin
            bus.mem_addr  = play_ptr_q;
            bus.tone_en   = 1'b1;
            bus.tone_note = cur_note_q;
            tmr_en        = 1'b1;
            if (tmr_done) begin
               if (({1'b0, play_ptr_q} + 1'b1) < count_q) begin
                  play_ptr_d = play_ptr_q + 1'b1;
                  state_d    = ST_PLAY_FETCH;
               end else if (loop_en) begin
                  play_ptr_d = '0;
                  state_d    = ST_PLAY_FETCH;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE && stop_press) begin
         state_d = ST_IDLE;
      end

`ifdef NOTE_SEQUENCER_LIVE_OVERRIDE_EN
      if (state_q != ST_IDLE && live_valid) begin
         bus.tone_en   = 1'b1;
         bus.tone_note = live_note;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         play_ptr_q  <= '0;
         cur_note_q  <= '0;
         rec_hist_q  <= 1'b1;
         play_hist_q <= 1'b1;
         stop_hist_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         play_ptr_q  <= play_ptr_d;
         cur_note_q  <= cur_note_d;
         rec_hist_q  <= rec_n;
         play_hist_q <= play_n;
         stop_hist_q <= stop_n;
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a 4-cycle beat and a 16x7
// behavioural note RAM; playback is checked against an expanded note timeline.
module tb_note_sequencer;

   localparam int TPB = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rec_n = 1'b1, play_n = 1'b1, stop_n = 1'b1, loop_en = 1'b0;
   logic [4:0] note_in = '0;
   logic [1:0] dur_in = '0;
   logic       live_valid = 1'b0;
   logic [4:0] live_note = '0;
   logic [1:0] state;
   logic [4:0] notes_recorded;
   logic       rec_full;

   note_sequencer_if #(.ADDR_W(4), .NOTE_W(5), .DUR_W(2)) bus ();

   note_sequencer #(
      .ADDR_W(4), .NOTE_W(5), .DUR_W(2), .TICKS_PER_BEAT(TPB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rec_n          (rec_n),
      .play_n         (play_n),
      .stop_n         (stop_n),
      .loop_en        (loop_en),
      .note_in        (note_in),
      .dur_in         (dur_in),
      .live_valid     (live_valid),
      .live_note      (live_note),
      .bus            (bus),
      .state          (state),
      .notes_recorded (notes_recorded),
      .rec_full       (rec_full)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: synchronous write, registered read (1-cycle latency).
   logic [6:0] ram [16];
   initial for (int i = 0; i < 16; i++) ram[i] = '0;
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int total = 0;
   int bad   = 0;

   // Reference model: what has been recorded, and the expected playback timeline.
   int         m_cnt = 0;
   logic [4:0] m_note [16];
   logic [1:0] m_dur  [16];
   logic       e_en   [$];
   logic [4:0] e_note [$];
   logic [1:0] e_st   [$];
   logic [3:0] e_addr [$];

   function automatic void model_rec(input logic [4:0] n, input logic [1:0] d);
      if (m_cnt < 16) begin
         m_note[m_cnt] = n;
         m_dur[m_cnt]  = d;
         m_cnt++;
      end
   endfunction

   // Each note is two silent cycles (fetch, load) then (dur+1)*TPB sounding cycles.
   function automatic void build_expect(input int passes);
      e_en.delete(); e_note.delete(); e_st.delete(); e_addr.delete();
      for (int p = 0; p < passes; p++)
         for (int k = 0; k < m_cnt; k++) begin
            e_en.push_back(1'b0); e_note.push_back('0); e_st.push_back(2'd1); e_addr.push_back(4'(k));
            e_en.push_back(1'b0); e_note.push_back('0); e_st.push_back(2'd2); e_addr.push_back(4'(k));
            for (int c = 0; c < (int'(m_dur[k]) + 1) * TPB; c++) begin
               e_en.push_back(1'b1); e_note.push_back(m_note[k]);
               e_st.push_back(2'd3); e_addr.push_back(4'(k));
            end
         end
   endfunction

   task automatic press_rec(input logic [4:0] n, input logic [1:0] d);
      @(posedge clk); #1 note_in = n; dur_in = d; rec_n = 1'b0;
      @(posedge clk); #1 rec_n = 1'b1;
      model_rec(n, d);
   endtask

   task automatic press_play();
      @(posedge clk); #1 play_n = 1'b0;
      @(posedge clk); #1 play_n = 1'b1;
   endtask

   task automatic press_stop();
      @(posedge clk); #1 stop_n = 1'b0;
      @(posedge clk); #1 stop_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({state, notes_recorded, rec_full, bus.mem_we, bus.mem_addr, bus.tone_en, bus.tone_note} !== 22'd0) begin
         bad++;
         $display("FAIL reset_hold: outputs=%h required all zero",
                  {state, notes_recorded, rec_full, bus.mem_we, bus.mem_addr, bus.tone_en, bus.tone_note});
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (state !== 2'd0 || notes_recorded !== 5'd0 || bus.mem_we !== 1'b0 || bus.tone_en !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: state=%0d cnt=%0d we=%b tone=%b required 0 0 0 0",
                  state, notes_recorded, bus.mem_we, bus.tone_en);
      end
   endtask

   task automatic test_record_fixed();
      int fn [3] = '{5, 9, 12};
      int fd [3] = '{0, 1, 3};
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1 note_in = 5'(fn[k]); dur_in = 2'(fd[k]); rec_n = 1'b0;
         @(negedge clk);
         total++;
         if (bus.mem_we !== 1'b1 || bus.mem_addr !== 4'(k) || bus.mem_wdata !== {2'(fd[k]), 5'(fn[k])}) begin
            bad++;
            $display("FAIL rec_write%0d: we=%b addr=%0d wdata=%h required 1 %0d %h",
                     k, bus.mem_we, bus.mem_addr, bus.mem_wdata, k, {2'(fd[k]), 5'(fn[k])});
         end
         @(posedge clk); #1 rec_n = 1'b1;
         model_rec(5'(fn[k]), 2'(fd[k]));
         @(negedge clk);
         total++;
         if (bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL rec_pulse%0d: we=%b required 0 on the held cycle", k, bus.mem_we);
         end
      end
      total++;
      if (notes_recorded !== 5'd3) begin
         bad++;
         $display("FAIL rec_count: notes_recorded=%0d required 3", notes_recorded);
      end
   endtask

   task automatic test_play();
      build_expect(1);
      press_play();
      for (int i = 0; i < e_en.size(); i++) begin
         @(negedge clk);
         total++;
         if (bus.tone_en !== e_en[i] || state !== e_st[i] ||
             (e_en[i] && bus.tone_note !== e_note[i]) ||
             (e_st[i] == 2'd1 && bus.mem_addr !== e_addr[i])) begin
            bad++;
            $display("FAIL play_cyc%0d: en=%b note=%0d st=%0d addr=%0d required en=%b note=%0d st=%0d addr=%0d",
                     i, bus.tone_en, bus.tone_note, state, bus.mem_addr, e_en[i], e_note[i], e_st[i], e_addr[i]);
         end
      end
      @(negedge clk);
      total++;
      if (state !== 2'd0 || bus.tone_en !== 1'b0) begin
         bad++;
         $display("FAIL play_end: state=%0d tone_en=%b required 0 0", state, bus.tone_en);
      end
   endtask

   task automatic test_record_random();
      int n;
      press_stop();
      m_cnt = 0;
      n = $urandom_range(2, 5);
      for (int k = 0; k < n; k++) press_rec(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      @(negedge clk);
      total++;
      if (notes_recorded !== 5'(n)) begin
         bad++;
         $display("FAIL rand_count: notes_recorded=%0d required %0d", notes_recorded, n);
      end
   endtask

   task automatic test_full();
      logic [4:0] n;
      logic [1:0] d;
      logic       exp_we;
      press_stop();
      m_cnt = 0;
      for (int k = 0; k < 17; k++) begin
         n = 5'($urandom_range(0, 31));
         d = 2'($urandom_range(0, 3));
         exp_we = (m_cnt < 16);
         @(posedge clk); #1 note_in = n; dur_in = d; rec_n = 1'b0;
         @(negedge clk);
         total++;
         if (bus.mem_we !== exp_we ||
             (exp_we && (bus.mem_addr !== 4'(m_cnt) || bus.mem_wdata !== {d, n}))) begin
            bad++;
            $display("FAIL full_press%0d: we=%b addr=%0d wdata=%h required we=%b addr=%0d wdata=%h",
                     k, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_we, m_cnt, {d, n});
         end
         @(posedge clk); #1 rec_n = 1'b1;
         model_rec(n, d);
      end
      @(negedge clk);
      total++;
      if (rec_full !== 1'b1 || notes_recorded !== 5'd16) begin
         bad++;
         $display("FAIL full_flag: rec_full=%b cnt=%0d required 1 16", rec_full, notes_recorded);
      end
      press_stop();
      m_cnt = 0;
      @(negedge clk);
      total++;
      if (notes_recorded !== 5'd0 || rec_full !== 1'b0) begin
         bad++;
         $display("FAIL erase: cnt=%0d rec_full=%b required 0 0", notes_recorded, rec_full);
      end
   endtask

   task automatic test_loop_stop();
      int s;
      press_rec(5'd7, 2'd0);
      press_rec(5'd3, 2'd1);
      loop_en = 1'b1;
      build_expect(2);
      // Fourth sounding cycle of the second note on the second pass.
      s = 2 * (2 + TPB + 2 + 2 * TPB) - (2 * TPB) + 3;
      press_play();
      for (int i = 0; i <= s; i++) begin
         @(negedge clk);
         total++;
         if (bus.tone_en !== e_en[i] || state !== e_st[i] || (e_en[i] && bus.tone_note !== e_note[i])) begin
            bad++;
            $display("FAIL loop_cyc%0d: en=%b note=%0d st=%0d required en=%b note=%0d st=%0d",
                     i, bus.tone_en, bus.tone_note, state, e_en[i], e_note[i], e_st[i]);
         end
         if (i == s - 1) begin
            @(posedge clk); #1 stop_n = 1'b0;
         end
      end
      @(posedge clk); #1 stop_n = 1'b1;
      loop_en = 1'b0;
      @(negedge clk);
      total++;
      if (state !== 2'd0 || bus.tone_en !== 1'b0) begin
         bad++;
         $display("FAIL loop_stop: state=%0d tone_en=%b required 0 0", state, bus.tone_en);
      end
      press_play();
      @(negedge clk);
      total++;
      if (state !== 2'd1 || bus.mem_addr !== 4'd0) begin
         bad++;
         $display("FAIL replay_addr: state=%0d addr=%0d required 1 0", state, bus.mem_addr);
      end
      repeat (2) @(negedge clk);
      total++;
      if (bus.tone_en !== 1'b1 || bus.tone_note !== 5'd7) begin
         bad++;
         $display("FAIL replay_note: en=%b note=%0d required 1 7", bus.tone_en, bus.tone_note);
      end
      press_stop();
   endtask

   task automatic test_async_reset();
      bit seen = 1'b0;
      press_play();
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.tone_en === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL areset_wait: tone_en never rose within 10 cycles, required 1");
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({state, notes_recorded, rec_full, bus.mem_we, bus.mem_addr, bus.tone_en, bus.tone_note} !== 22'd0) begin
         bad++;
         $display("FAIL areset_now: outputs=%h required all zero",
                  {state, notes_recorded, rec_full, bus.mem_we, bus.mem_addr, bus.tone_en, bus.tone_note});
      end
      @(negedge clk) reset = 1'b1;
      m_cnt = 0;
      press_play();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (state !== 2'd0 || bus.tone_en !== 1'b0) begin
            bad++;
            $display("FAIL empty_play%0d: state=%0d tone_en=%b required 0 0", i, state, bus.tone_en);
         end
      end
   endtask

   task automatic test_priority_live();
      logic [4:0] ln;
      logic [4:0] rec_note;
      logic [4:0] exp_note;
      press_rec(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      press_rec(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      @(posedge clk); #1 play_n = 1'b0; stop_n = 1'b0;
      @(posedge clk); #1 play_n = 1'b1; stop_n = 1'b1;
      m_cnt = 0;
      @(negedge clk);
      total++;
      if (state !== 2'd0 || notes_recorded !== 5'd0) begin
         bad++;
         $display("FAIL play_stop_prio: state=%0d cnt=%0d required 0 0", state, notes_recorded);
      end
      repeat (3) @(negedge clk);
      total++;
      if (state !== 2'd0 || bus.tone_en !== 1'b0) begin
         bad++;
         $display("FAIL prio_idle: state=%0d tone_en=%b required 0 0", state, bus.tone_en);
      end
      ln = 5'($urandom_range(1, 31));
      #1 live_note = ln; live_valid = 1'b1;
      #1;
      total++;
      if (bus.tone_en !== 1'b1 || bus.tone_note !== ln) begin
         bad++;
         $display("FAIL live_on: en=%b note=%0d required 1 %0d", bus.tone_en, bus.tone_note, ln);
      end
      live_valid = 1'b0;
      #1;
      total++;
      if (bus.tone_en !== 1'b0) begin
         bad++;
         $display("FAIL live_off: en=%b required 0", bus.tone_en);
      end
      // Live key held during playback.
      rec_note = (ln == 5'd31) ? 5'd0 : ln + 5'd1;
      press_rec(rec_note, 2'd1);
      press_play();
      live_valid = 1'b1;
      repeat (4) @(negedge clk);
`ifdef NOTE_SEQUENCER_LIVE_OVERRIDE_EN
      exp_note = ln;
`else
      exp_note = rec_note;
`endif
      total++;
      if (bus.tone_en !== 1'b1 || bus.tone_note !== exp_note) begin
         bad++;
         $display("FAIL live_in_play: en=%b note=%0d required 1 %0d", bus.tone_en, bus.tone_note, exp_note);
      end
      live_valid = 1'b0;
      press_stop();
   endtask

   initial begin
      #2 reset = 1'b0;
      test_reset();
      test_record_fixed();
      test_play();
      test_record_random();
      test_play();
      test_full();
      test_loop_stop();
      test_async_reset();
      test_priority_live();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Record/playback scheduler for the music device's note memory and tone generator. Records up to 16 notes, each with a duration, into an external synchronous RAM. Plays them back at a fixed beat rate, with optional looping. Arbitrates the single tone generator between live keys and playback. Sits between the debounced button/switch inputs and the note RAM plus tone generator.

Parameters:
ADDR_W, 4, note RAM address width; capacity = 2**ADDR_W notes
NOTE_W, 5, note code width
DUR_W, 2, duration field width; duration in beats = dur+1
TICKS_PER_BEAT, 12500000, clk cycles per beat (0.25 s at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
rec_n  in  1  record button, active-low, already synchronised
play_n  in  1  play button, active-low
stop_n  in  1  stop button, active-low; in IDLE it erases the recording
loop_en  in  1  level switch; repeat playback when high
note_in  in  NOTE_W  note to record
dur_in  in  DUR_W  duration to record
live_valid  in  1  live key held
live_note  in  NOTE_W  live key note code
mem_we  out  1  RAM write strobe
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  NOTE_W+DUR_W  {dur, note}
mem_rdata  in  NOTE_W+DUR_W  RAM read data, valid 1 cycle after the address
tone_en  out  1  tone generator enable
tone_note  out  NOTE_W  tone generator note
state  out  2  current state, for LEDs
notes_recorded  out  ADDR_W+1  stored note count, 0..16
rec_full  out  1  high when notes_recorded == 2**ADDR_W

Behaviour:
- Reset: asynchronous and active-low, so it applies at any time, including mid-playback. On reset:
  - state goes to IDLE, and all counters and pointers clear.
  - mem_we=0, mem_addr=0, tone_en=0, tone_note=0, notes_recorded=0.
  - Button history registers are set to 1.
  - RAM contents are not cleared.
- Press detection: a press is a registered 1->0 transition of the button. One press gives exactly one event; holding the button gives no repeats.
- Event priority when presses coincide: stop > play > rec.
- States: IDLE=0, PLAY_FETCH=1, PLAY_LOAD=2, PLAY_NOTE=3. Recording happens from IDLE; there is no separate record state.
- IDLE, rec press with count < 16:
  - One-cycle pulse: mem_we=1, mem_addr=count[ADDR_W-1:0], mem_wdata={dur_in, note_in}.
  - Count increments on the same edge.
- IDLE, rec press at count == 16: ignored; no write is issued.
- IDLE, stop press: notes_recorded <= 0.
- IDLE, play press with count > 0: play_ptr <= 0, go to PLAY_FETCH. With count == 0 the press is ignored.
- IDLE tone output: tone_en=live_valid, tone_note=live_note (combinational pass-through).
- PLAY_FETCH: mem_addr=play_ptr, tone_en=0; next cycle go to PLAY_LOAD.
- PLAY_LOAD: capture mem_rdata into cur_note/cur_dur, load beat_cnt=cur_dur, load tick_cnt=TICKS_PER_BEAT-1, go to PLAY_NOTE.
- PLAY_NOTE: tone_en=1, tone_note=cur_note.
  - tick_cnt decrements each cycle.
  - At tick_cnt==0 with beat_cnt>0: beat_cnt decrements and tick_cnt reloads.
  - At tick_cnt==0 with beat_cnt==0, the note ends:
    - If play_ptr+1 < count: play_ptr increments, go to PLAY_FETCH.
    - Otherwise, with loop_en=1: play_ptr <= 0, go to PLAY_FETCH.
    - Otherwise: go to IDLE.
- Note length: exactly (dur+1)*TICKS_PER_BEAT cycles with tone_en=1, followed by a 2-cycle silent gap (FETCH and LOAD) before the next note.
- Stop press in any PLAY_* state: go to IDLE on the next edge, tone_en=0 from that cycle. The recording is kept.
- Play or rec presses during playback are ignored.
- The beat counter runs only in PLAY_NOTE; there is no free-running divider.

Optional Feature:
NOTE_SEQUENCER_LIVE_OVERRIDE_EN.
- Defined: in PLAY_* states, live_valid=1 forces tone_en=1 and tone_note=live_note. Playback timing continues unchanged underneath.
- Undefined: live input is ignored outside IDLE.

Decomposition:
- Shared package music_pkg:
  - state encoding localparams.
  - NOTE_W, DUR_W, ADDR_W defaults.
  - TICKS_PER_BEAT default.
- One sub-module: beat_timer. It holds tick_cnt and beat_cnt, with inputs load, dur and enable, and output done.
- Press detection and the FSM stay in note_sequencer.

Test Plan:
Bench settings are TICKS_PER_BEAT=4 with a 16x7 behavioural RAM of 1-cycle read latency.
1. Record 3 notes (note 5/dur 0, note 9/dur 1, note 12/dur 3) -> 3 single-cycle mem_we pulses at addresses 0,1,2; notes_recorded=3.
2. Play with loop_en=0 -> tone_en high for 4, 8 and 16 cycles with notes 5, 9, 12, each preceded by 2 low cycles; then state=IDLE.
3. Record 17 presses -> 16 writes, rec_full=1, the 17th press is ignored; stop in IDLE -> notes_recorded=0.
4. Play with loop_en=1 and stop asserted mid-second-note -> tone_en=0 and state=IDLE one edge later; a replay starts at address 0.
5. Assert reset low mid-PLAY_NOTE, asynchronously -> all outputs zero immediately; play with count=0 afterwards -> stays in IDLE.
6. play_n and stop_n pressed in the same cycle in IDLE with count=2 -> recording is erased, no playback starts; live_valid in IDLE -> tone_en follows it combinationally.
